// File: rtl/timer_pkg.sv
// Shared encodings for the timer controller: operating modes, FSM states and
// the mode bit positions used to decode direction and repeat behaviour.
package timer_pkg;

   typedef enum logic [1:0] {
      MODE_OS_UP  = 2'b00,
      MODE_PER_UP = 2'b01,
      MODE_OS_DN  = 2'b10,
      MODE_PER_DN = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RUN  = 2'b10
   } state_e;

   localparam int MODE_DOWN_BIT     = 1;
   localparam int MODE_PERIODIC_BIT = 0;

endpackage

// File: rtl/timer_ctrl_if.sv
// Config/status bundle between the register block (master) and the timer
// controller (slave).
interface timer_ctrl_if
   import timer_pkg::*;
#(
   parameter int BITS     = 16,
   parameter int PSC_BITS = 8
) ();

   logic                start;
   logic                stop;
   mode_e               mode;
   logic [BITS-1:0]     period;
   logic [PSC_BITS-1:0] prescale;
   logic                irq_clr;
   logic                busy;
   logic [BITS-1:0]     count;
   logic                tick;
   logic                done;
   logic                irq;

   modport master (
      output start, stop, mode, period, prescale, irq_clr,
      input  busy, count, tick, done, irq
   );

   modport slave (
      input  start, stop, mode, period, prescale, irq_clr,
      output busy, count, tick, done, irq
   );

endinterface

// File: rtl/timer_ctrl_counter.sv
// Library up/down counter with synchronous load, wrap at top (up) or reload
// of top at zero (down), and a combinational terminal (overflow) flag.
module timer_ctrl_counter #(
   parameter int BITS = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_load,
   input  logic [BITS-1:0] i_load_val,
   input  logic            i_ena,
   input  logic            i_updown,
   input  logic [BITS-1:0] i_top,
   output logic [BITS-1:0] o_count,
   output logic            o_ovf
);

   logic [BITS-1:0] r_count;
   logic            w_ovf;

   assign w_ovf = i_updown ? (r_count == i_top) : (r_count == '0);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from before the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_ena) begin
         if (w_ovf)
            r_count <= i_updown ? '0 : i_top;
         else
            r_count <= i_updown ? r_count + BITS'(1) : r_count - BITS'(1);
      end
   end

   assign o_count = r_count;
   assign o_ovf   = w_ovf;

endmodule

// File: rtl/timer_ctrl.sv
// Timer controller: latches config on start, sequences LOAD/RUN of the library
// counter through a prescaler, and reports tick, one-shot done and sticky irq.
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int BITS     = 16,
   parameter int PSC_BITS = 8
) (
   input  logic         clk,
   input  logic         rst,
   timer_ctrl_if.slave  bus
);

   state_e              r_state;
   state_e              w_state_nxt;
   mode_e               r_mode;
   logic [BITS-1:0]     r_period;
   logic [PSC_BITS-1:0] r_psc;
   logic [PSC_BITS-1:0] r_psc_cnt;
   logic                r_tick;
   logic                r_done;
   logic                r_irq;

   logic                w_start_acc;
   logic                w_step;
   logic                w_down;
   logic                w_periodic;
   logic                w_load;
   logic                w_ena;
   logic                w_tick_nxt;
   logic                w_done_nxt;
   logic [BITS-1:0]     w_count;
   logic                w_ovf;

   // A simultaneous stop cancels the start.
   assign w_start_acc = bus.start & ~bus.stop;
   assign w_step      = (r_psc_cnt == r_psc);
   assign w_down      = r_mode[MODE_DOWN_BIT];
   assign w_periodic  = r_mode[MODE_PERIODIC_BIT];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   // NOTE: every output of this block is given a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_ena       = 1'b0;
      w_tick_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start_acc) w_state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            w_load = 1'b1;
            if (bus.stop)       w_state_nxt = ST_IDLE;
            else if (bus.start) w_state_nxt = ST_LOAD;
            else                w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (bus.stop) begin
               w_state_nxt = ST_IDLE;
            end else if (bus.start) begin
               w_state_nxt = ST_LOAD;
            end else if (w_step) begin
               if (w_ovf) begin
                  w_tick_nxt = 1'b1;
                  // One-shot holds its terminal value instead of wrapping.
                  if (w_periodic) begin
                     w_ena = 1'b1;
                  end else begin
                     w_done_nxt  = 1'b1;
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_ena = 1'b1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mode   <= MODE_OS_UP;
         r_period <= '0;
         r_psc    <= '0;
      end else if (w_start_acc) begin
         r_mode   <= bus.mode;
         r_period <= bus.period;
         r_psc    <= bus.prescale;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_psc_cnt <= '0;
      end else if (r_state == ST_LOAD) begin
         r_psc_cnt <= '0;
      end else if (r_state == ST_RUN) begin
         r_psc_cnt <= w_step ? '0 : r_psc_cnt + PSC_BITS'(1);
      end
   end

   // A new tick takes priority over a coincident irq_clr.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tick <= 1'b0;
         r_done <= 1'b0;
         r_irq  <= 1'b0;
      end else begin
         r_tick <= w_tick_nxt;
         r_done <= w_done_nxt;
         r_irq  <= w_tick_nxt | (r_irq & ~bus.irq_clr);
      end
   end

   timer_ctrl_counter #(
      .BITS (BITS)
   ) u_counter (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (w_down ? r_period : '0),
      .i_ena      (w_ena),
      .i_updown   (~w_down),
      .i_top      (r_period),
      .o_count    (w_count),
      .o_ovf      (w_ovf)
   );

   assign bus.busy  = (r_state != ST_IDLE);
   assign bus.count = w_count;
   assign bus.tick  = r_tick;
   assign bus.done  = r_done;
   assign bus.irq   = r_irq;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: expected tick events are queued when a timer
// is started and matched by a monitor whenever the DUT raises tick or done.
module tb_timer_ctrl;
   import timer_pkg::*;

   localparam int BITS     = 16;
   localparam int PSC_BITS = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   timer_ctrl_if #(.BITS(BITS), .PSC_BITS(PSC_BITS)) bus ();

   timer_ctrl #(.BITS(BITS), .PSC_BITS(PSC_BITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Edge counter: after posedge N (and #1) cyc == N.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int              cyc;
      logic [BITS-1:0] count;
      logic            done;
      logic            busy;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_tick(input int c, input int cnt, input logic d, input logic b);
      exp_t e;
      e.cyc   = c;
      e.count = BITS'(cnt);
      e.done  = d;
      e.busy  = b;
      sb_q.push_back(e);
   endtask

   // Monitor: every tick/done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst && (bus.tick || bus.done)) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_pulse: tick=%0b done=%0b at cycle %0d, none expected",
                     bus.tick, bus.done, cyc);
         end else begin
            mon_e = sb_q.pop_front();
            check("tick_cycle", 32'(cyc), 32'(mon_e.cyc));
            check("tick_level", 32'(bus.tick), 32'd1);
            check("tick_count", 32'(bus.count), 32'(mon_e.count));
            check("tick_done", 32'(bus.done), 32'(mon_e.done));
            check("tick_busy", 32'(bus.busy), 32'(mon_e.busy));
            check("tick_irq", 32'(bus.irq), 32'd1);
         end
      end
   end

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_edge(input int t);
      while (cyc < t) next_edge();
   endtask

   // Start is sampled on the next edge, returned as e0; the config inputs are
   // then scrambled to show they are only used when latched.
   task automatic do_start(input mode_e m, input int p, input int s, output int e0);
      bus.mode     = m;
      bus.period   = BITS'(p);
      bus.prescale = PSC_BITS'(s);
      bus.start    = 1'b1;
      e0           = cyc + 1;
      next_edge();
      bus.start    = 1'b0;
      bus.mode     = MODE_OS_UP;
      bus.period   = '1;
      bus.prescale = '1;
   endtask

   task automatic pulse_stop();
      bus.stop = 1'b1;
      next_edge();
      bus.stop = 1'b0;
   endtask

   task automatic pulse_clr();
      bus.irq_clr = 1'b1;
      next_edge();
      bus.irq_clr = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d expected < 10000", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      int e1;
      int exp_dn[8];
      exp_dn = '{2, 2, 1, 1, 0, 0, 0, 0};

      bus.start    = 1'b0;
      bus.stop     = 1'b0;
      bus.mode     = MODE_OS_UP;
      bus.period   = '0;
      bus.prescale = '0;
      bus.irq_clr  = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_tick", 32'(bus.tick), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_irq", 32'(bus.irq), 32'd0);
      rst = 1'b1;
      next_edge();
      next_edge();

      // Periodic up, period 3, prescale 0
      do_start(MODE_PER_UP, 3, 0, e0);
      push_tick(e0 + 5, 0, 1'b0, 1'b1);
      push_tick(e0 + 9, 0, 1'b0, 1'b1);
      push_tick(e0 + 13, 0, 1'b0, 1'b1);
      check("t1_busy_load", 32'(bus.busy), 32'd1);
      for (int k = 1; k <= 8; k++) begin
         wait_edge(e0 + k);
         check("t1_count", 32'(bus.count), 32'((k - 1) % 4));
      end
      wait_edge(e0 + 14);
      pulse_stop();
      wait_edge(e0 + 16);
      check("t1_busy_stop", 32'(bus.busy), 32'd0);
      check("t1_count_frozen", 32'(bus.count), 32'd1);
      check("t1_irq_sticky", 32'(bus.irq), 32'd1);
      pulse_clr();
      check("t1_irq_clr", 32'(bus.irq), 32'd0);

      // One-shot down, period 2, prescale 1
      do_start(MODE_OS_DN, 2, 1, e0);
      push_tick(e0 + 7, 0, 1'b1, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         wait_edge(e0 + k);
         check("t2_count", 32'(bus.count), 32'(exp_dn[k-1]));
         if (k == 6) check("t2_busy_run", 32'(bus.busy), 32'd1);
         if (k == 8) check("t2_busy_done", 32'(bus.busy), 32'd0);
      end
      wait_edge(e0 + 10);
      check("t2_count_hold", 32'(bus.count), 32'd0);
      check("t2_irq_sticky", 32'(bus.irq), 32'd1);
      pulse_clr();
      check("t2_irq_clr", 32'(bus.irq), 32'd0);

      // Periodic up, period 0, prescale 2
      do_start(MODE_PER_UP, 0, 2, e0);
      push_tick(e0 + 4, 0, 1'b0, 1'b1);
      push_tick(e0 + 7, 0, 1'b0, 1'b1);
      push_tick(e0 + 10, 0, 1'b0, 1'b1);
      for (int k = 1; k <= 9; k++) begin
         wait_edge(e0 + k);
         check("t3_count", 32'(bus.count), 32'd0);
      end
      wait_edge(e0 + 11);
      pulse_stop();
      wait_edge(e0 + 14);
      check("t3_busy_stop", 32'(bus.busy), 32'd0);
      pulse_clr();

      // Stop mid-run at count 5, then start+stop together
      do_start(MODE_PER_UP, 10, 0, e0);
      wait_edge(e0 + 6);
      check("t4_count_pre", 32'(bus.count), 32'd5);
      pulse_stop();
      wait_edge(e0 + 9);
      check("t4_count_frozen", 32'(bus.count), 32'd5);
      check("t4_busy_stop", 32'(bus.busy), 32'd0);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      next_edge();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      check("t4_busy_both", 32'(bus.busy), 32'd0);
      repeat (3) next_edge();
      check("t4_count_both", 32'(bus.count), 32'd5);
      check("t4_irq_none", 32'(bus.irq), 32'd0);

      // Restart while running: periodic down, period 1
      do_start(MODE_PER_UP, 10, 0, e0);
      wait_edge(e0 + 4);
      check("t5_count_pre", 32'(bus.count), 32'd3);
      do_start(MODE_PER_DN, 1, 0, e1);
      push_tick(e1 + 3, 1, 1'b0, 1'b1);
      push_tick(e1 + 5, 1, 1'b0, 1'b1);
      push_tick(e1 + 7, 1, 1'b0, 1'b1);
      check("t5_busy_load", 32'(bus.busy), 32'd1);
      for (int k = 1; k <= 8; k++) begin
         wait_edge(e1 + k);
         check("t5_count", 32'(bus.count), 32'(k % 2));
      end

      // Async reset while a tick is pending
      wait_edge(e1 + 9);
      check("t6_tick_pre", 32'(bus.tick), 32'd1);
      check("t6_irq_pre", 32'(bus.irq), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("t6_busy", 32'(bus.busy), 32'd0);
      check("t6_tick", 32'(bus.tick), 32'd0);
      check("t6_done", 32'(bus.done), 32'd0);
      check("t6_irq", 32'(bus.irq), 32'd0);
      check("t6_count", 32'(bus.count), 32'd0);
      next_edge();
      rst = 1'b1;
      repeat (10) next_edge();
      check("t6_idle_busy", 32'(bus.busy), 32'd0);
      check("t6_idle_count", 32'(bus.count), 32'd0);
      check("t6_idle_irq", 32'(bus.irq), 32'd0);

      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
